// File: rtl/io_keysw.sv
// ---------------------------------------------------------------------------
// io_keysw
//
// Memory-mapped pushbutton (KEY) and slide-switch (SW) peripheral for the
// memory stage of a simple pipelined CPU. It exposes four bus registers:
//
//   KDATA  {28'b0, pressed[3:0]}  KEY level, 1 = button held (pins active-low)
//   KCTRL  bit0 Ready, bit2 Overrun, bit4 IE
//   SDATA  {22'b0, sw[9:0]}       debounced switch positions
//   SCTRL  bit0 Ready, bit2 Overrun, bit4 IE
//
// Ready flags a new data value that software has not yet read, Overrun
// flags that a value was replaced before it was read, and IE enables the
// corresponding source onto the level interrupt.
//
// Ports
//   clk        sole clock, rising-edge
//   RESET_N    asynchronous, active-low reset
//   KEY[3:0]   raw pushbuttons, active-low, asynchronous to clk
//   SW[9:0]    raw slide switches, asynchronous to clk
//   memaddr_M  bus address
//   wmemval_M  bus write data
//   wrmem_M    one-cycle write strobe
//   rdmem_M    one-cycle read strobe
//   sel_M      high when memaddr_M hits one of the four registers
//   rdata_M    combinational read data (0 when not selected)
//   intr       registered level interrupt request
// ---------------------------------------------------------------------------
module io_keysw #(
  parameter int unsigned       DBITS     = 32,
  parameter logic [DBITS-1:0]  ADDRKDATA = 32'hFFFFF080,
  parameter logic [DBITS-1:0]  ADDRKCTRL = 32'hFFFFF084,
  parameter logic [DBITS-1:0]  ADDRSDATA = 32'hFFFFF090,
  parameter logic [DBITS-1:0]  ADDRSCTRL = 32'hFFFFF094,
  // Must be at least 2: the commit happens on the edge the counter
  // reaches DEBCYCLES-1, which is detected one value earlier.
  parameter int unsigned       DEBCYCLES = 500000
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] memaddr_M,
  input  logic [DBITS-1:0] wmemval_M,
  input  logic             wrmem_M,
  input  logic             rdmem_M,
  output logic             sel_M,
  output logic [DBITS-1:0] rdata_M,
  output logic             intr
);

  // Debounce counter only ever needs to hold 0 .. DEBCYCLES-1.
  localparam int unsigned CNTW = (DEBCYCLES > 2) ? $clog2(DEBCYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBCYCLES - 1);
  localparam logic [CNTW-1:0] CNT_PRE = CNTW'(DEBCYCLES - 2);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0]      key_meta_q, key_meta_d;
  logic [3:0]      key_sync_q, key_sync_d;
  logic [9:0]      sw_meta_q,  sw_meta_d;
  logic [9:0]      sw_sync_q,  sw_sync_d;

  logic [3:0]      kdata_q,    kdata_d;
  logic [9:0]      sdata_q,    sdata_d;
  logic [9:0]      sw_cand_q,  sw_cand_d;
  logic [CNTW-1:0] deb_cnt_q,  deb_cnt_d;

  logic            k_ready_q,  k_ready_d;
  logic            k_ovr_q,    k_ovr_d;
  logic            k_ie_q,     k_ie_d;
  logic            s_ready_q,  s_ready_d;
  logic            s_ovr_q,    s_ovr_d;
  logic            s_ie_q,     s_ie_d;
  logic            intr_q,     intr_d;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  logic k_rd, s_rd, k_ctrl_wr, s_ctrl_wr;

  assign hit_kdata = (memaddr_M == ADDRKDATA);
  assign hit_kctrl = (memaddr_M == ADDRKCTRL);
  assign hit_sdata = (memaddr_M == ADDRSDATA);
  assign hit_sctrl = (memaddr_M == ADDRSCTRL);

  assign sel_M = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

  // Only data reads have a side effect (they acknowledge Ready); writes to
  // the data registers are simply not decoded.
  assign k_rd      = rdmem_M & hit_kdata;
  assign s_rd      = rdmem_M & hit_sdata;
  assign k_ctrl_wr = wrmem_M & hit_kctrl;
  assign s_ctrl_wr = wrmem_M & hit_sctrl;

  // Only bits 2 (Overrun keep) and 4 (IE) of the write data mean anything.
  logic unused_wdata;
  assign unused_wdata = ^{wmemval_M[DBITS-1:5], wmemval_M[3], wmemval_M[1:0]};

  // -------------------------------------------------------------------------
  // Register views as seen on the bus
  // -------------------------------------------------------------------------
  logic [DBITS-1:0] kdata_word, kctrl_word, sdata_word, sctrl_word;

  assign kdata_word = {{(DBITS-4){1'b0}}, kdata_q};
  assign sdata_word = {{(DBITS-10){1'b0}}, sdata_q};
  assign kctrl_word = {{(DBITS-5){1'b0}}, k_ie_q, 1'b0, k_ovr_q, 1'b0, k_ready_q};
  assign sctrl_word = {{(DBITS-5){1'b0}}, s_ie_q, 1'b0, s_ovr_q, 1'b0, s_ready_q};

  always_comb begin
    rdata_M = '0;
    if (hit_kdata)      rdata_M = kdata_word;
    else if (hit_kctrl) rdata_M = kctrl_word;
    else if (hit_sdata) rdata_M = sdata_word;
    else if (hit_sctrl) rdata_M = sctrl_word;
  end

  // -------------------------------------------------------------------------
  // Input synchronizers and KEY data
  // -------------------------------------------------------------------------
  logic k_chg;

  always_comb begin
    key_meta_d = KEY;
    key_sync_d = key_meta_q;
    sw_meta_d  = SW;
    sw_sync_d  = sw_meta_q;
    // Buttons are active-low on the pins; software sees 1 = pressed.
    kdata_d    = ~key_sync_q;
    k_chg      = (kdata_d != kdata_q);
  end

  // -------------------------------------------------------------------------
  // Switch debouncer
  // A new synchronized value becomes the candidate and restarts the count;
  // the candidate is committed on the edge the counter arrives at
  // DEBCYCLES-1, after which the counter parks there until SW moves again.
  // -------------------------------------------------------------------------
  logic sw_commit, s_chg;

  always_comb begin
    sw_cand_d = sw_cand_q;
    deb_cnt_d = deb_cnt_q;
    sw_commit = 1'b0;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q != CNT_MAX) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
      sw_commit = (deb_cnt_q == CNT_PRE);
    end
    sdata_d = sw_commit ? sw_cand_q : sdata_q;
    // Re-committing the value already held is not a new event.
    s_chg   = (sdata_d != sdata_q);
  end

  // -------------------------------------------------------------------------
  // Status flags
  // A change always (re)asserts Ready, so a change coinciding with a data
  // read leaves Ready set and is not an overrun. A control write clears
  // Overrun unless bit 2 is written as 1; a simultaneous overrun event wins
  // so that a lost value is never silently forgotten.
  // -------------------------------------------------------------------------
  always_comb begin
    k_ready_d = k_ready_q;
    k_ovr_d   = k_ovr_q;
    k_ie_d    = k_ie_q;
    if (k_chg)     k_ready_d = 1'b1;
    else if (k_rd) k_ready_d = 1'b0;
    if (k_ctrl_wr) begin
      k_ie_d = wmemval_M[4];
      if (!wmemval_M[2]) k_ovr_d = 1'b0;
    end
    if (k_chg && k_ready_q && !k_rd) k_ovr_d = 1'b1;
  end

  always_comb begin
    s_ready_d = s_ready_q;
    s_ovr_d   = s_ovr_q;
    s_ie_d    = s_ie_q;
    if (s_chg)     s_ready_d = 1'b1;
    else if (s_rd) s_ready_d = 1'b0;
    if (s_ctrl_wr) begin
      s_ie_d = wmemval_M[4];
      if (!wmemval_M[2]) s_ovr_d = 1'b0;
    end
    if (s_chg && s_ready_q && !s_rd) s_ovr_d = 1'b1;
  end

  // Interrupt is a registered copy of the current enabled-ready sources,
  // so it trails Ready/IE by one edge.
  always_comb begin
    intr_d = (k_ready_q & k_ie_q) | (s_ready_q & s_ie_q);
  end

  assign intr = intr_q;

  // -------------------------------------------------------------------------
  // State registers. KEY synchronizers reset to all-ones (released buttons)
  // so that leaving reset does not look like a key press.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      kdata_q    <= '0;
      sdata_q    <= '0;
      sw_cand_q  <= '0;
      deb_cnt_q  <= '0;
      k_ready_q  <= 1'b0;
      k_ovr_q    <= 1'b0;
      k_ie_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      s_ovr_q    <= 1'b0;
      s_ie_q     <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      kdata_q    <= kdata_d;
      sdata_q    <= sdata_d;
      sw_cand_q  <= sw_cand_d;
      deb_cnt_q  <= deb_cnt_d;
      k_ready_q  <= k_ready_d;
      k_ovr_q    <= k_ovr_d;
      k_ie_q     <= k_ie_d;
      s_ready_q  <= s_ready_d;
      s_ovr_q    <= s_ovr_d;
      s_ie_q     <= s_ie_d;
      intr_q     <= intr_d;
    end
  end

endmodule
